// File: rtl/stream_out_port_if.sv
// AXI4-Stream video bus between the VDMA read port and its downstream sink.
// Latency: none, plain wires.
// Backpressure: tready from the slave stalls the master.
interface stream_out_port_if #(parameter int DSIZE = 24);
   logic [DSIZE-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tuser;
   logic             tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/stream_out_port.sv
// VDMA read-side output port: drains the read FIFO into an AXI4-Stream video frame.
// Latency: FIFO read in cycle n -> tvalid in cycle n+2; 1 pixel/cycle sustained.
// Backpressure: 2-entry output buffer absorbs tready stalls; reads throttle on buffer credit.
// Optional STREAM_OUT_FSYNC_EN: every frame waits in WAIT_SYNC for an fsync pulse.
module stream_out_port #(
   parameter int DSIZE = 24
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             aclken,
   input  logic [15:0]      vactive,
   input  logic [15:0]      hactive,
   input  logic             fsync,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [DSIZE-1:0] fifo_rdata,
   stream_out_port_if.master axi,
   output logic             frame_done
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STREAM    = 2'd1,
      FRAME_END = 2'd2
`ifdef STREAM_OUT_FSYNC_EN
      , WAIT_SYNC = 2'd3
`endif
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [15:0]      hactive_l;
   logic [15:0]      vactive_l;
   logic [15:0]      hcnt;
   logic [15:0]      vcnt;
   logic [31:0]      rd_cnt;
   logic [31:0]      frame_words;

   logic             inflight;
   logic [DSIZE-1:0] buf_mem [0:1];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       buf_cnt;

   logic             pop;
   logic             line_end;
   logic             frame_last;
   logic [2:0]       occ;
   logic             rd_ok;

`ifndef STREAM_OUT_FSYNC_EN
   logic             unused_fsync;
   assign unused_fsync = fsync;
`endif

   assign frame_words = 32'(hactive_l) * 32'(vactive_l);
   assign pop         = axi.tvalid & axi.tready & aclken;
   assign line_end    = (hcnt == hactive_l - 16'd1);
   assign frame_last  = pop & line_end & (vcnt == vactive_l - 16'd1);

   // A slot freed by this cycle's pop counts as credit, otherwise the
   // read/pop pipeline could only sustain 2 pixels every 3 cycles.
   assign occ   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign rd_ok = (occ < 3'd2);

   // State register; frozen while the clock enable is low.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
      end else if (aclken) begin
         state <= state_nxt;
      end
   end

   // Next-state: frames start only with nonzero sizes and end on the last handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if ((hactive != 16'd0) && (vactive != 16'd0)) begin
`ifdef STREAM_OUT_FSYNC_EN
               state_nxt = WAIT_SYNC;
`else
               state_nxt = STREAM;
`endif
            end
         end
`ifdef STREAM_OUT_FSYNC_EN
         WAIT_SYNC: begin
            if (fsync) state_nxt = STREAM;
         end
`endif
         STREAM: begin
            if (frame_last) state_nxt = FRAME_END;
         end
         FRAME_END: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // FSM outputs: FIFO read strobe while streaming with credit, done pulse after the frame.
   always_comb begin
      fifo_rd_en = aclken & (state == STREAM) & ~fifo_empty &
                   (rd_cnt < frame_words) & rd_ok;
      frame_done = (state == FRAME_END);
   end

   // Frame geometry latch plus read and pixel position counters.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         hactive_l <= '0;
         vactive_l <= '0;
         rd_cnt    <= '0;
         hcnt      <= '0;
         vcnt      <= '0;
      end else if (aclken) begin
         if (state == IDLE) begin
            hactive_l <= hactive;
            vactive_l <= vactive;
            rd_cnt    <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
         end else begin
            if (fifo_rd_en) rd_cnt <= rd_cnt + 32'd1;
            if (pop) begin
               if (line_end) begin
                  hcnt <= '0;
                  vcnt <= vcnt + 16'd1;
               end else begin
                  hcnt <= hcnt + 16'd1;
               end
            end
         end
      end
   end

   // Tracks the read issued last cycle; its data arrives this cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
      end
   end

   // Output buffer: in-flight data is written regardless of the clock enable.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < 2; i++) buf_mem[i] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         buf_cnt <= 2'd0;
      end else begin
         if (inflight) begin
            buf_mem[wr_ptr] <= fifo_rdata;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({inflight, pop})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

   // Head entry drives the stream; markers only while valid so idle outputs read 0.
   assign axi.tdata  = buf_mem[rd_ptr];
   assign axi.tvalid = (buf_cnt != 2'd0);
   assign axi.tuser  = axi.tvalid & (hcnt == 16'd0) & (vcnt == 16'd0);
   assign axi.tlast  = axi.tvalid & line_end;

endmodule

// File: tb/tb_stream_out_port.sv
// Directed bench for stream_out_port: FIFO model, handshake monitor, per-scenario tasks.
// Cycle numbers count from the cycle in which reset is released (cycle 0 = IDLE).
module tb_stream_out_port;
   localparam int DSIZE = 24;
`ifdef STREAM_OUT_FSYNC_EN
   localparam int SL = 1;
`else
   localparam int SL = 0;
`endif

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             aclken = 1'b1;
   logic             fsync = 1'b0;
   logic [15:0]      hactive = 16'd4;
   logic [15:0]      vactive = 16'd2;
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [DSIZE-1:0] fifo_rdata = '0;
   logic             frame_done;

   stream_out_port_if #(.DSIZE(DSIZE)) axi ();

   stream_out_port #(.DSIZE(DSIZE)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .aclken     (aclken),
      .vactive    (vactive),
      .hactive    (hactive),
      .fsync      (fsync),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .axi        (axi),
      .frame_done (frame_done)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   // FIFO model with 1-cycle read latency
   logic [DSIZE-1:0] fmem [$];
   int               wr_idx = 0;
   int               rd_idx = 0;
   int               rd_n = 0;
   logic             flush_req = 1'b0;
   logic             starve = 1'b0;
   logic             fsync_hold = (SL != 0);

   assign fifo_empty = (rd_idx == wr_idx) | starve;

   always @(posedge aclk) begin
      if (flush_req) begin
         rd_idx <= wr_idx;
      end else if (fifo_rd_en) begin
         fifo_rdata <= fmem[rd_idx];
         rd_idx     <= rd_idx + 1;
         rd_n       <= rd_n + 1;
      end
   end

   // Handshake / frame_done recorder and stall-stability monitor
   int               cyc = 0;
   logic [DSIZE-1:0] hs_dat [$];
   logic             hs_usr [$];
   logic             hs_lst [$];
   int               hs_cyc [$];
   int               fd_cyc [$];
   int               stall_err = 0;
   int               buf_err = 0;
   logic             prev_stall = 1'b0;
   logic [DSIZE-1:0] prev_dat = '0;
   logic             prev_usr = 1'b0;
   logic             prev_lst = 1'b0;

   always @(posedge aclk) begin
      cyc <= cyc + 1;
      if (aresetn) begin
         if (axi.tvalid && axi.tready && aclken) begin
            hs_dat.push_back(axi.tdata);
            hs_usr.push_back(axi.tuser);
            hs_lst.push_back(axi.tlast);
            hs_cyc.push_back(cyc);
         end
         if (frame_done) fd_cyc.push_back(cyc);
         if (prev_stall && (!axi.tvalid || axi.tdata !== prev_dat ||
                            axi.tuser !== prev_usr || axi.tlast !== prev_lst))
            stall_err <= stall_err + 1;
         if (dut.buf_cnt > 2'd2) buf_err <= buf_err + 1;
         prev_stall <= axi.tvalid && !(axi.tready && aclken);
         prev_dat   <= axi.tdata;
         prev_usr   <= axi.tuser;
         prev_lst   <= axi.tlast;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   int rel, hs0, fd0, rd0, se0, be0;

   // Reset, flush the FIFO model, preload n words from 'first', release in a fresh cycle 0.
   task automatic restart(input int first, input int n, input logic [15:0] h, input logic [15:0] v);
      aresetn    = 1'b0;
      aclken     = 1'b1;
      axi.tready = 1'b1;
      starve     = 1'b0;
      fsync      = fsync_hold;
      hactive    = h;
      vactive    = v;
      flush_req  = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      flush_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         fmem.push_back(DSIZE'(first + i));
         wr_idx++;
      end
      @(negedge aclk);
      aresetn = 1'b1;
      rel = cyc;
      hs0 = hs_dat.size();
      fd0 = fd_cyc.size();
      rd0 = rd_n;
      se0 = stall_err;
      be0 = buf_err;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      checks++; if (axi.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", axi.tvalid); end
      checks++; if (axi.tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got %b exp 0", axi.tuser); end
      checks++; if (axi.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", axi.tlast); end
      checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
      checks++; if (axi.tdata !== '0) begin errors++; $display("FAIL reset_tdata got %0d exp 0", axi.tdata); end
   endtask

   task automatic test_baseline();
      // 12 words available, only 8 may be read for a 4x2 frame
      restart(1, 12, 16'd4, 16'd2);
      for (int i = 0; i < 200 && fd_cyc.size() < fd0 + 1; i++) @(negedge aclk);
      checks++; if (fd_cyc.size() != fd0 + 1) begin errors++; $display("FAIL base_done got %0d exp 1", fd_cyc.size() - fd0); $fatal(1, "FAIL base_done timeout"); end
      checks++; if (hs_dat.size() - hs0 != 8) begin errors++; $display("FAIL base_count got %0d exp 8", hs_dat.size() - hs0); end
      checks++; if (rd_n - rd0 != 8) begin errors++; $display("FAIL base_reads got %0d exp 8", rd_n - rd0); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (hs_dat[hs0+i] !== DSIZE'(i + 1)) begin errors++; $display("FAIL base_data[%0d] got %0d exp %0d", i, hs_dat[hs0+i], i + 1); end
         checks++; if (hs_cyc[hs0+i] != rel + 3 + SL + i) begin errors++; $display("FAIL base_cycle[%0d] got %0d exp %0d", i, hs_cyc[hs0+i] - rel, 3 + SL + i); end
         checks++; if (hs_usr[hs0+i] !== (i == 0)) begin errors++; $display("FAIL base_tuser[%0d] got %b exp %b", i, hs_usr[hs0+i], i == 0); end
         checks++; if (hs_lst[hs0+i] !== (i == 3 || i == 7)) begin errors++; $display("FAIL base_tlast[%0d] got %b exp %b", i, hs_lst[hs0+i], i == 3 || i == 7); end
      end
      checks++; if (fd_cyc[fd0] != rel + 11 + SL) begin errors++; $display("FAIL base_done_cycle got %0d exp %0d", fd_cyc[fd0] - rel, 11 + SL); end
   endtask

   task automatic test_back_to_back();
      restart(1, 16, 16'd4, 16'd2);
      for (int i = 0; i < 300 && fd_cyc.size() < fd0 + 2; i++) @(negedge aclk);
      checks++; if (fd_cyc.size() != fd0 + 2) begin errors++; $display("FAIL b2b_frames got %0d exp 2", fd_cyc.size() - fd0); $fatal(1, "FAIL b2b timeout"); end
      checks++; if (hs_dat.size() - hs0 != 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", hs_dat.size() - hs0); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (hs_dat[hs0+i] !== DSIZE'(i + 1)) begin errors++; $display("FAIL b2b_data[%0d] got %0d exp %0d", i, hs_dat[hs0+i], i + 1); end
      end
      // gap: FRAME_END in 11, IDLE in 12, STREAM from 13, first pixel of frame 2 in 15
      checks++; if (fd_cyc[fd0] != rel + 11 + SL) begin errors++; $display("FAIL b2b_done0 got %0d exp %0d", fd_cyc[fd0] - rel, 11 + SL); end
      checks++; if (hs_cyc[hs0+8] != rel + 15 + 2 * SL) begin errors++; $display("FAIL b2b_f2_start got %0d exp %0d", hs_cyc[hs0+8] - rel, 15 + 2 * SL); end
      checks++; if (hs_usr[hs0+8] !== 1'b1) begin errors++; $display("FAIL b2b_f2_tuser got %b exp 1", hs_usr[hs0+8]); end
      checks++; if (fd_cyc[fd0+1] != rel + 23 + 2 * SL) begin errors++; $display("FAIL b2b_done1 got %0d exp %0d", fd_cyc[fd0+1] - rel, 23 + 2 * SL); end
   endtask

   task automatic test_back_pressure();
      restart(1, 8, 16'd4, 16'd2);
      for (int c = 1; c < 300 && fd_cyc.size() < fd0 + 1; c++) begin
         @(negedge aclk);
         axi.tready = (c >= 8 && c < 13) ? 1'b0 : (c % 2 == 0);
      end
      axi.tready = 1'b1;
      checks++; if (fd_cyc.size() != fd0 + 1) begin errors++; $display("FAIL bp_done got %0d exp 1", fd_cyc.size() - fd0); $fatal(1, "FAIL bp timeout"); end
      checks++; if (hs_dat.size() - hs0 != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", hs_dat.size() - hs0); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (hs_dat[hs0+i] !== DSIZE'(i + 1)) begin errors++; $display("FAIL bp_data[%0d] got %0d exp %0d", i, hs_dat[hs0+i], i + 1); end
      end
      checks++; if (hs_lst[hs0+3] !== 1'b1 || hs_lst[hs0+7] !== 1'b1) begin errors++; $display("FAIL bp_tlast got %b%b exp 11", hs_lst[hs0+3], hs_lst[hs0+7]); end
      checks++; if (stall_err != se0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_err - se0); end
      checks++; if (buf_err != be0) begin errors++; $display("FAIL bp_buf_cnt got %0d overfull cycles exp 0", buf_err - be0); end
      checks++; if (rd_n - rd0 != 8) begin errors++; $display("FAIL bp_reads got %0d exp 8", rd_n - rd0); end
   endtask

   task automatic test_starvation();
      restart(1, 8, 16'd4, 16'd2);
      // FIFO looks empty in cycles 4..6, right after the third word was read
      for (int c = 1; c < 300 && fd_cyc.size() < fd0 + 1; c++) begin
         @(negedge aclk);
         starve = (c >= 4 + SL && c < 7 + SL);
         if (c == 7 + SL || c == 8 + SL) begin
            checks++; if (axi.tvalid !== 1'b0) begin errors++; $display("FAIL starve_gap_tvalid cycle %0d got %b exp 0", c, axi.tvalid); end
         end
      end
      starve = 1'b0;
      checks++; if (fd_cyc.size() != fd0 + 1) begin errors++; $display("FAIL starve_done got %0d exp 1", fd_cyc.size() - fd0); $fatal(1, "FAIL starve timeout"); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (hs_dat[hs0+i] !== DSIZE'(i + 1)) begin errors++; $display("FAIL starve_data[%0d] got %0d exp %0d", i, hs_dat[hs0+i], i + 1); end
      end
      checks++; if (hs_cyc[hs0+2] != rel + 5 + SL) begin errors++; $display("FAIL starve_px3_cycle got %0d exp %0d", hs_cyc[hs0+2] - rel, 5 + SL); end
      checks++; if (hs_cyc[hs0+3] != rel + 9 + SL) begin errors++; $display("FAIL starve_px4_cycle got %0d exp %0d", hs_cyc[hs0+3] - rel, 9 + SL); end
      checks++; if (hs_lst[hs0+3] !== 1'b1) begin errors++; $display("FAIL starve_px4_tlast got %b exp 1", hs_lst[hs0+3]); end
      checks++; if (fd_cyc[fd0] != rel + 14 + SL) begin errors++; $display("FAIL starve_done_cycle got %0d exp %0d", fd_cyc[fd0] - rel, 14 + SL); end
   endtask

   task automatic test_aclken();
      restart(1, 8, 16'd4, 16'd2);
      // first read in cycle 1; enable low in cycles 2 and 3
      for (int c = 1; c < 300 && fd_cyc.size() < fd0 + 1; c++) begin
         @(negedge aclk);
         aclken = !(c == 2 + SL || c == 3 + SL);
         if (c == 3 + SL) begin
            checks++; if (axi.tvalid !== 1'b1) begin errors++; $display("FAIL clken_captured_tvalid got %b exp 1", axi.tvalid); end
            checks++; if (axi.tdata !== DSIZE'(1)) begin errors++; $display("FAIL clken_captured_tdata got %0d exp 1", axi.tdata); end
         end
      end
      aclken = 1'b1;
      checks++; if (fd_cyc.size() != fd0 + 1) begin errors++; $display("FAIL clken_done got %0d exp 1", fd_cyc.size() - fd0); $fatal(1, "FAIL clken timeout"); end
      checks++; if (hs_dat.size() - hs0 != 8) begin errors++; $display("FAIL clken_count got %0d exp 8", hs_dat.size() - hs0); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (hs_dat[hs0+i] !== DSIZE'(i + 1)) begin errors++; $display("FAIL clken_data[%0d] got %0d exp %0d", i, hs_dat[hs0+i], i + 1); end
      end
      checks++; if (hs_cyc[hs0] != rel + 4 + SL) begin errors++; $display("FAIL clken_px1_cycle got %0d exp %0d", hs_cyc[hs0] - rel, 4 + SL); end
      checks++; if (hs_cyc[hs0+1] != rel + 6 + SL) begin errors++; $display("FAIL clken_px2_cycle got %0d exp %0d", hs_cyc[hs0+1] - rel, 6 + SL); end
      checks++; if (fd_cyc[fd0] != rel + 13 + SL) begin errors++; $display("FAIL clken_done_cycle got %0d exp %0d", fd_cyc[fd0] - rel, 13 + SL); end
      checks++; if (rd_n - rd0 != 8) begin errors++; $display("FAIL clken_reads got %0d exp 8", rd_n - rd0); end
   endtask

   task automatic test_reset_mid_frame();
      restart(1, 8, 16'd4, 16'd2);
      for (int i = 0; i < 100 && hs_dat.size() < hs0 + 5; i++) @(negedge aclk);
      checks++; if (hs_dat.size() != hs0 + 5) begin errors++; $display("FAIL rst_mid_reach got %0d pixels exp 5", hs_dat.size() - hs0); end
      aresetn = 1'b0;
      #1;
      checks++; if ({axi.tvalid, axi.tuser, axi.tlast, fifo_rd_en, frame_done} !== 5'b0) begin
         errors++; $display("FAIL rst_mid_ctrl got %b exp 00000", {axi.tvalid, axi.tuser, axi.tlast, fifo_rd_en, frame_done});
      end
      checks++; if (axi.tdata !== '0) begin errors++; $display("FAIL rst_mid_tdata got %0d exp 0", axi.tdata); end
      restart(101, 8, 16'd4, 16'd2);
      for (int i = 0; i < 200 && fd_cyc.size() < fd0 + 1; i++) @(negedge aclk);
      checks++; if (fd_cyc.size() != fd0 + 1) begin errors++; $display("FAIL rst_new_done got %0d exp 1", fd_cyc.size() - fd0); $fatal(1, "FAIL rst_new timeout"); end
      checks++; if (hs_dat.size() - hs0 != 8) begin errors++; $display("FAIL rst_new_count got %0d exp 8", hs_dat.size() - hs0); end
      checks++; if (hs_usr[hs0] !== 1'b1) begin errors++; $display("FAIL rst_new_tuser got %b exp 1", hs_usr[hs0]); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (hs_dat[hs0+i] !== DSIZE'(101 + i)) begin errors++; $display("FAIL rst_new_data[%0d] got %0d exp %0d", i, hs_dat[hs0+i], 101 + i); end
      end
   endtask

   task automatic test_zero_size();
      restart(1, 8, 16'd0, 16'd2);
      repeat (20) @(negedge aclk);
      checks++; if (rd_n - rd0 != 0) begin errors++; $display("FAIL zero_h_reads got %0d exp 0", rd_n - rd0); end
      checks++; if (hs_dat.size() - hs0 != 0) begin errors++; $display("FAIL zero_h_pixels got %0d exp 0", hs_dat.size() - hs0); end
      restart(1, 8, 16'd4, 16'd0);
      repeat (20) @(negedge aclk);
      checks++; if (rd_n - rd0 != 0) begin errors++; $display("FAIL zero_v_reads got %0d exp 0", rd_n - rd0); end
   endtask

`ifdef STREAM_OUT_FSYNC_EN
   task automatic test_fsync();
      fsync_hold = 1'b0;
      restart(1, 8, 16'd4, 16'd2);
      repeat (10) @(negedge aclk);
      checks++; if (rd_n - rd0 != 0) begin errors++; $display("FAIL fsync_wait_reads got %0d exp 0", rd_n - rd0); end
      checks++; if (axi.tvalid !== 1'b0) begin errors++; $display("FAIL fsync_wait_tvalid got %b exp 0", axi.tvalid); end
      // pulse seen in cycle 10 -> STREAM from 11 -> first pixel in 13
      fsync = 1'b1;
      @(negedge aclk);
      fsync = 1'b0;
      for (int i = 0; i < 200 && fd_cyc.size() < fd0 + 1; i++) @(negedge aclk);
      checks++; if (fd_cyc.size() != fd0 + 1) begin errors++; $display("FAIL fsync_done got %0d exp 1", fd_cyc.size() - fd0); $fatal(1, "FAIL fsync timeout"); end
      checks++; if (hs_cyc[hs0] != rel + 13) begin errors++; $display("FAIL fsync_first_cycle got %0d exp 13", hs_cyc[hs0] - rel); end
      checks++; if (hs_dat[hs0] !== DSIZE'(1)) begin errors++; $display("FAIL fsync_first_data got %0d exp 1", hs_dat[hs0]); end
      fsync_hold = 1'b1;
   endtask
`endif

   initial begin
      axi.tready = 1'b1;
      test_reset();
      test_baseline();
      test_back_to_back();
      test_back_pressure();
      test_starvation();
      test_aclken();
      test_reset_mid_frame();
      test_zero_size();
`ifdef STREAM_OUT_FSYNC_EN
      test_fsync();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
